// File: rtl/ne16_package.sv
// Shared types for the ne16 normquant datapath.
package ne16_package;

    localparam logic [1:0] QMODE_8  = 2'd0;
    localparam logic [1:0] QMODE_16 = 2'd1;
    localparam logic [1:0] QMODE_32 = 2'd2;

    typedef struct packed {
        logic [1:0] quant_mode;
        logic       relu;
        logic       use_shifting;
        logic       use_rounding;
    } ctrl_normquant_t;

endpackage

// File: rtl/ne16_normquant_shifter_stream_if.sv
// Input and output beat streams of the normquant shifter.
// A beat transfers on a rising clk edge where valid & ready are both high; the source
// holds valid and its payload stable until that edge, ready may depend combinationally on valid.
interface ne16_normquant_shifter_stream_if #(
    parameter int N_CH = 8,
    parameter int INT  = 33,
    parameter int ACC  = 32
) ();

    logic                            in_valid;
    logic                            in_ready;
    logic [N_CH*INT-1:0]             in_data;
    logic [N_CH*6-1:0]               in_shift;
    ne16_package::ctrl_normquant_t   in_ctrl;

    logic                            out_valid;
    logic                            out_ready;
    logic [N_CH*ACC-1:0]             out_data;
    logic [N_CH-1:0]                 out_sat_mask;

    modport slave (
        input  in_valid, in_data, in_shift, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_sat_mask
    );

    modport master (
        output in_valid, in_data, in_shift, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_sat_mask
    );

endinterface

// File: rtl/ne16_normquant_shifter_stream.sv
// Multi-channel normquant shifter: S1 rounds and shifts, S2 saturates/ReLUs,
// with a saturating count of saturated channels across delivered beats.
module ne16_normquant_shifter_stream #(
    parameter int N_CH      = 8,
    parameter int INT       = 33,
    parameter int ACC       = 32,
    parameter int SAT_CNT_W = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    ne16_normquant_shifter_stream_if.slave      io,
    output logic [SAT_CNT_W-1:0]                sat_cnt_o
);

    localparam int SUM_W = SAT_CNT_W + $clog2(N_CH + 1);

    logic                              s1_valid_q, s2_valid_q;
    logic                              s1_en, s2_en;
    logic signed [INT:0]               s1_r_d [N_CH];
    logic signed [INT:0]               s1_r_q [N_CH];
    ne16_package::ctrl_normquant_t     s1_ctrl_q;
    logic [N_CH*ACC-1:0]               s2_data_d, s2_data_q;
    logic [N_CH-1:0]                   s2_sat_d, s2_sat_q;
    logic [SAT_CNT_W-1:0]              sat_cnt_q, sat_cnt_d;
    logic [SUM_W-1:0]                  pop_cnt, cnt_sum;

    assign s2_en       = ~s2_valid_q | io.out_ready;
    assign s1_en       = ~s1_valid_q | s2_en;
    assign io.in_ready = s1_en & ~clear_i;

    assign io.out_valid    = s2_valid_q;
    assign io.out_data     = s2_data_q;
    assign io.out_sat_mask = s2_sat_q;
    assign sat_cnt_o       = sat_cnt_q;

    // S1: clamp shift to 32, optional round-half-up, arithmetic right shift in INT+1 bits
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            logic [5:0]          sh;
            logic signed [INT:0] t;
            logic signed [INT:0] rnd;
            sh  = io.in_shift[c*6 +: 6];
            if (sh > 6'd32) sh = 6'd32;
            t   = {io.in_data[c*INT + INT - 1], io.in_data[c*INT +: INT]};
            rnd = '0;
            if (io.in_ctrl.use_shifting && io.in_ctrl.use_rounding && sh != 6'd0)
                rnd = {{INT{1'b0}}, 1'b1} << (sh - 6'd1);
            t = t + rnd;
            s1_r_d[c] = io.in_ctrl.use_shifting ? (t >>> sh) : t;
        end
    end

    // S2: narrow to 8/16/32 bits, clamping and flagging out-of-range values
    always_comb begin
        s2_data_d = '0;
        s2_sat_d  = '0;
        for (int c = 0; c < N_CH; c++) begin
            int                  w;
            logic signed [INT:0] r, res, low, max_u, max_s, min_s;
            logic signed [ACC+INT:0] ext;
            logic                sat;
            r = s1_r_q[c];
            case (s1_ctrl_q.quant_mode)
                ne16_package::QMODE_8:  w = 8;
                ne16_package::QMODE_16: w = 16;
                default:                w = 32;
            endcase
            max_u = ({{INT{1'b0}}, 1'b1} << w) - 1'b1;
            max_s = ({{INT{1'b0}}, 1'b1} << (w - 1)) - 1'b1;
            min_s = -({{INT{1'b0}}, 1'b1} << (w - 1));
            low   = (r <<< (INT + 1 - w)) >>> (INT + 1 - w);
            sat   = 1'b0;
            res   = r;
            if (!s1_ctrl_q.use_shifting) begin
                res = low;
            end else if (s1_ctrl_q.relu) begin
                if (r < 0) begin
                    res = '0;
                end else if (r > max_u) begin
                    res = max_u;
                    sat = 1'b1;
                end
            end else begin
                if (r < min_s) begin
                    res = min_s;
                    sat = 1'b1;
                end else if (r > max_s) begin
                    res = max_s;
                    sat = 1'b1;
                end
            end
            ext = res;
            s2_data_d[c*ACC +: ACC] = ext[ACC-1:0];
            s2_sat_d[c]             = sat;
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int c = 0; c < N_CH; c++) pop_cnt = pop_cnt + SUM_W'(s2_sat_q[c]);
        cnt_sum = SUM_W'(sat_cnt_q) + pop_cnt;
        if (cnt_sum > SUM_W'({SAT_CNT_W{1'b1}})) sat_cnt_d = {SAT_CNT_W{1'b1}};
        else                                     sat_cnt_d = cnt_sum[SAT_CNT_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
            sat_cnt_q  <= '0;
            for (int c = 0; c < N_CH; c++) s1_r_q[c] <= '0;
        end else if (clear_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            if (s2_valid_q && io.out_ready) sat_cnt_q <= sat_cnt_d;
            if (s1_en) begin
                s1_valid_q <= io.in_valid;
                if (io.in_valid) begin
                    s1_r_q    <= s1_r_d;
                    s1_ctrl_q <= io.in_ctrl;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                    s2_sat_q  <= s2_sat_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_ne16_normquant_shifter_stream.sv
// Directed bench for ne16_normquant_shifter_stream with hand-computed expected beats.
module tb_ne16_normquant_shifter_stream;
    import ne16_package::*;

    localparam int N_CH  = 8;
    localparam int INT   = 33;
    localparam int ACC   = 32;
    localparam int EXP_W = N_CH*ACC + N_CH;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] sat_cnt;
    logic [3:0]  sat_cnt4;

    always #5 clk = ~clk;

    ne16_normquant_shifter_stream_if #(.N_CH(N_CH), .INT(INT), .ACC(ACC)) io ();
    ne16_normquant_shifter_stream_if #(.N_CH(N_CH), .INT(INT), .ACC(ACC)) io4 ();

    ne16_normquant_shifter_stream #(.N_CH(N_CH), .INT(INT), .ACC(ACC), .SAT_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .io(io), .sat_cnt_o(sat_cnt)
    );

    ne16_normquant_shifter_stream #(.N_CH(N_CH), .INT(INT), .ACC(ACC), .SAT_CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .io(io4), .sat_cnt_o(sat_cnt4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int acc_cyc  = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_cur;
    int               out_cyc[$];

    logic signed [INT-1:0] d[N_CH];
    logic [5:0]            s[N_CH];
    logic [31:0]           e[N_CH];
    logic [7:0]            m;
    ctrl_normquant_t       ctrl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Output scoreboard: every delivered beat is compared channel by channel
    always @(negedge clk) begin
        if (!rst && !clear && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                exp_cur = exp_q.pop_front();
                for (int c = 0; c < N_CH; c++)
                    check($sformatf("beat_ch%0d", c), io.out_data[c*ACC +: ACC], exp_cur[c*32 +: 32]);
                check("beat_sat_mask", {24'd0, io.out_sat_mask}, {24'd0, exp_cur[EXP_W-1 -: 8]});
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic set_ctrl(input logic [1:0] qm, input logic relu, input logic shf, input logic rnd);
        ctrl.quant_mode   = qm;
        ctrl.relu         = relu;
        ctrl.use_shifting = shf;
        ctrl.use_rounding = rnd;
    endtask

    task automatic set_ch(input int c, input logic signed [INT-1:0] dv, input logic [5:0] sv,
                          input logic [31:0] ev);
        d[c] = dv;
        s[c] = sv;
        e[c] = ev;
    endtask

    function automatic logic [EXP_W-1:0] pack_exp();
        logic [EXP_W-1:0] x;
        for (int c = 0; c < N_CH; c++) x[c*32 +: 32] = e[c];
        x[EXP_W-1 -: 8] = m;
        return x;
    endfunction

    // Present one beat (called just after a posedge) and hold it until accepted
    task automatic send(input logic track);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            io.in_data[c*INT +: INT] = d[c];
            io.in_shift[c*6 +: 6]    = s[c];
        end
        io.in_ctrl  = ctrl;
        io.in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (io.in_ready) begin
                ok = 1'b1;
                n_acc++;
                acc_cyc = cyc;
                if (track) exp_q.push_back(pack_exp());
            end
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic beat_g();
        set_ctrl(QMODE_8, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) set_ch(c, 300, 6'd0, 32'h7F);
        for (int c = 5; c < 8; c++) set_ch(c, 3, 6'd0, 32'h3);
        m = 8'h1F;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clear = 1'b0;
        io.in_valid = 1'b0; io.out_ready = 1'b1; io.in_data = '0; io.in_shift = '0; io.in_ctrl = '0;
        io4.in_valid = 1'b0; io4.out_ready = 1'b1; io4.in_data = '0; io4.in_shift = '0; io4.in_ctrl = '0;
        ctrl = '0; m = '0;
        for (int c = 0; c < N_CH; c++) set_ch(c, 0, 6'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("rst_data_any", {31'd0, |io.out_data}, 32'd0);
        check("rst_sat_mask", {24'd0, io.out_sat_mask}, 32'd0);
        check("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, io.in_ready}, 32'd1);

        // A: 8B signed, rounding
        set_ctrl(QMODE_8, 1'b0, 1'b1, 1'b1);
        set_ch(0, 248, 6'd4, 32'h10);       set_ch(1, -5, 6'd0, 32'hFFFFFFFB);
        set_ch(2, -9, 6'd1, 32'hFFFFFFFC);  set_ch(3, 5000, 6'd2, 32'h7F);
        set_ch(4, -5000, 6'd2, 32'hFFFFFF80); set_ch(5, 100, 6'd40, 32'h0);
        set_ch(6, -100, 6'd63, 32'h0);      set_ch(7, 127, 6'd0, 32'h7F);
        m = 8'h18; send(1'b1);
        // B: 8B signed, truncating
        set_ctrl(QMODE_8, 1'b0, 1'b1, 1'b0);
        set_ch(0, 248, 6'd4, 32'hF);        set_ch(1, -5000, 6'd2, 32'hFFFFFF80);
        set_ch(2, -1, 6'd5, 32'hFFFFFFFF);  set_ch(3, 128, 6'd0, 32'h7F);
        set_ch(4, -128, 6'd0, 32'hFFFFFF80); set_ch(5, -129, 6'd0, 32'hFFFFFF80);
        set_ch(6, 1023, 6'd3, 32'h7F);      set_ch(7, 1024, 6'd3, 32'h7F);
        m = 8'hAA; send(1'b1);
        // C: 16B ReLU, rounding
        set_ctrl(QMODE_16, 1'b1, 1'b1, 1'b1);
        set_ch(0, -1, 6'd0, 32'h0);         set_ch(1, 200000, 6'd1, 32'hFFFF);
        set_ch(2, 65535, 6'd0, 32'hFFFF);   set_ch(3, 65536, 6'd0, 32'hFFFF);
        set_ch(4, 1000, 6'd3, 32'd125);     set_ch(5, 7, 6'd2, 32'd2);
        set_ch(6, -3, 6'd1, 32'h0);         set_ch(7, 131070, 6'd1, 32'hFFFF);
        m = 8'h0A; send(1'b1);
        // D: shifting disabled, 16B wrap with sign extension
        set_ctrl(QMODE_16, 1'b1, 1'b0, 1'b1);
        set_ch(0, 33'h12345, 6'd5, 32'h2345); set_ch(1, 33'h18000, 6'd0, 32'hFFFF8000);
        set_ch(2, -1, 6'd0, 32'hFFFFFFFF);  set_ch(3, 70000, 6'd0, 32'h1170);
        set_ch(4, 0, 6'd0, 32'h0);          set_ch(5, 33'hFFFF, 6'd0, 32'hFFFFFFFF);
        set_ch(6, 5, 6'd0, 32'h5);          set_ch(7, -40000, 6'd0, 32'h63C0);
        m = 8'h00; send(1'b1);
        // E: 32B signed at the extremes of the input range
        set_ctrl(QMODE_32, 1'b0, 1'b1, 1'b1);
        set_ch(0, 33'h0FFFFFFFF, 6'd0, 32'h7FFFFFFF); set_ch(1, 33'h100000000, 6'd0, 32'h80000000);
        set_ch(2, 33'h0FFFFFFFF, 6'd1, 32'h7FFFFFFF); set_ch(3, 33'h0FFFFFFFE, 6'd1, 32'h7FFFFFFF);
        set_ch(4, 33'h100000000, 6'd1, 32'h80000000); set_ch(5, 33'h100000000, 6'd32, 32'hFFFFFFFF);
        set_ch(6, 12345, 6'd0, 32'h3039);   set_ch(7, -12345, 6'd0, 32'hFFFFCFC7);
        m = 8'h07; send(1'b1);
        // F: unused quant_mode behaves as 32B, ReLU
        set_ctrl(2'b11, 1'b1, 1'b1, 1'b0);
        set_ch(0, 33'h0FFFFFFFF, 6'd0, 32'hFFFFFFFF); set_ch(1, -7, 6'd0, 32'h0);
        set_ch(2, 8, 6'd3, 32'h1);
        for (int c = 3; c < 8; c++) set_ch(c, 0, 6'd0, 32'h0);
        m = 8'h00; send(1'b1);
        drain();
        check("cnt_after_directed", {16'd0, sat_cnt}, 32'd11);

        // Backpressure: two beats fill the pipe, the rest wait
        out_cyc.delete(); n_acc = 0; io.out_ready = 1'b0;
        fork
            begin
                set_ctrl(QMODE_8, 1'b0, 1'b1, 1'b0);
                for (int k = 0; k < 4; k++) begin
                    for (int c = 0; c < N_CH; c++) set_ch(c, k*16 + c, 6'd0, 32'(k*16 + c));
                    m = 8'h00;
                    send(1'b1);
                end
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_accepted", n_acc, 32'd2);
                check("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, io.out_valid}, 32'd1);
                @(posedge clk);
                @(negedge clk);
                check("bp_hold_data", io.out_data[7*ACC +: ACC], 32'd7);
                check("bp_hold_ready", {31'd0, io.in_ready}, 32'd0);
                @(posedge clk);
                #1;
                io.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_out_count", out_cyc.size(), 32'd4);
        for (int i = 1; i < out_cyc.size(); i++)
            check($sformatf("bp_gap%0d", i), out_cyc[i] - out_cyc[i-1], 32'd1);

        // Clear with a saturated beat stalled in S2 and another beat offered
        io.out_ready = 1'b0;
        beat_g(); send(1'b0);
        @(posedge clk); #1;
        check("clr_stalled_valid", {31'd0, io.out_valid}, 32'd1);
        clear = 1'b1; io.out_ready = 1'b1; io.in_valid = 1'b1;
        #1;
        check("clr_in_ready", {31'd0, io.in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; io.in_valid = 1'b0;
        check("clr_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("clr_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clr_dropped", {31'd0, io.out_valid}, 32'd0);
        check("clr_cnt_hold", {16'd0, sat_cnt}, 32'd0);
        @(posedge clk); #1;

        // Counter: three beats of five saturated channels
        for (int k = 0; k < 3; k++) begin
            beat_g(); send(1'b1);
        end
        drain();
        check("cnt_15", {16'd0, sat_cnt}, 32'd15);

        // Asynchronous reset with two beats in flight
        io.out_ready = 1'b0;
        beat_g(); send(1'b0); send(1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("arst_data_any", {31'd0, |io.out_data}, 32'd0);
        check("arst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; io.out_ready = 1'b1;
        out_cyc.delete();
        set_ctrl(QMODE_8, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < N_CH; c++) set_ch(c, -9, 6'd1, 32'hFFFFFFFC);
        m = 8'h00; send(1'b1);
        drain();
        check("lat_count", out_cyc.size(), 32'd1);
        if (out_cyc.size() > 0) check("lat_cycles", out_cyc[0] - acc_cyc, 32'd2);

        // 4-bit counter saturates instead of wrapping
        check("c4_reset", {28'd0, sat_cnt4}, 32'd0);
        io4.in_ctrl = '{quant_mode: QMODE_8, relu: 1'b0, use_shifting: 1'b1, use_rounding: 1'b0};
        for (int c = 0; c < N_CH; c++) begin
            io4.in_data[c*INT +: INT] = 33'd1000;
            io4.in_shift[c*6 +: 6]    = 6'd0;
        end
        check("c4_in_ready", {31'd0, io4.in_ready}, 32'd1);
        io4.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        io4.in_valid = 1'b0;
        @(posedge clk); #1;
        check("c4_first", {28'd0, sat_cnt4}, 32'd8);
        @(posedge clk); #1;
        check("c4_sat", {28'd0, sat_cnt4}, 32'd15);
        io4.in_valid = 1'b1;
        @(posedge clk); #1;
        io4.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("c4_hold", {28'd0, sat_cnt4}, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
